// File: rtl/imem_port_arb.sv
// rtl/imem_port_arb.sv - byte-wide instruction memory port shared by a 32-bit fetcher and a byte loader
// Optional feature: define IMEM_ALIGN_CHK_EN to answer misaligned fetches with fetch_err instead of reading them.
module imem_port_arb #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [31:0]       fetch_data,
  output logic              fetch_err,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    DONE = 3'd3,
    WR   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [ADDR_W-1:0] addr_q;     // latched base address of the granted request
  logic [7:0]        wdata_q;    // latched loader byte
  logic [1:0]        byte_idx;   // byte offset of the read issued this RD cycle
  logic [31:0]       data_q;     // instruction being assembled / last one returned
  logic              last_load;  // most recent grant went to the loader
  logic              grant_fetch;
  logic              grant_load;
  logic              misaligned;

  // Only the low ADDR_W bits of the fetch address reach the memory.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^fetch_addr[31:ADDR_W];

`ifdef IMEM_ALIGN_CHK_EN
  logic err_q;  // the fetch in flight was misaligned

  assign misaligned = (fetch_addr[1:0] != 2'b00);

  // Remember whether the granted fetch is reported as an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (grant_fetch) begin
      err_q <= misaligned;
    end
  end

  assign fetch_err = (state == DONE) && err_q;
`else
  assign misaligned = 1'b0;
  assign fetch_err  = 1'b0;
`endif

  // Arbitration: grants only from IDLE, round-robin when both ask; a reset cycle ignores requests.
  always_comb begin
    grant_fetch = 1'b0;
    grant_load  = 1'b0;
    if ((state == IDLE) && !rst) begin
      if (fetch_req && load_req) begin
        grant_fetch = last_load;
        grant_load  = !last_load;
      end else begin
        grant_fetch = fetch_req;
        grant_load  = load_req;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: four reads, one trailing capture, one result cycle; loads take a single write cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_fetch) begin
          state_nxt = misaligned ? DONE : RD;
        end else if (grant_load) begin
          state_nxt = WR;
        end
      end
      RD:      if (byte_idx == 2'd3) state_nxt = CAP;
      CAP:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latching, read-offset counter and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      byte_idx  <= 2'd0;
      last_load <= 1'b1;  // first contended grant after reset goes to the fetcher
    end else if (grant_fetch) begin
      addr_q    <= fetch_addr[ADDR_W-1:0];
      byte_idx  <= 2'd0;
      last_load <= 1'b0;
    end else if (grant_load) begin
      addr_q    <= load_addr;
      wdata_q   <= load_data;
      last_load <= 1'b1;
    end else if (state == RD) begin
      byte_idx  <= byte_idx + 2'd1;
    end
  end

  // Assemble the instruction: read data lags the strobe by one cycle, so byte k lands one cycle after it was addressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (grant_fetch && misaligned) begin
      data_q <= '0;
    end else if (state == RD) begin
      case (byte_idx)
        2'd1:    data_q[7:0]   <= mem_rdata;
        2'd2:    data_q[15:8]  <= mem_rdata;
        2'd3:    data_q[23:16] <= mem_rdata;
        default: data_q        <= data_q;
      endcase
    end else if (state == CAP) begin
      data_q[31:24] <= mem_rdata;
    end
  end

  // Memory strobes exist only in RD and WR; the read address wraps modulo the memory size.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      RD: begin
        mem_en   = 1'b1;
        mem_addr = addr_q + {{(ADDR_W-2){1'b0}}, byte_idx};
      end
      WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  assign fetch_gnt   = grant_fetch;
  assign load_gnt    = grant_load;
  assign fetch_valid = (state == DONE);
  assign fetch_data  = data_q;

endmodule

// File: tb/tb_imem_port_arb.sv
// tb/tb_imem_port_arb.sv - scoreboard bench for imem_port_arb
module tb_imem_port_arb;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [31:0]       fetch_data;
  logic              fetch_err;
  logic              load_req;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic              load_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'h00;

  imem_port_arb #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_gnt(load_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-wide memory model with one-cycle read latency.
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Scoreboards: expected memory accesses {we, addr, wdata} and expected fetch results {err, data}.
  logic [ADDR_W+8:0] acc_q [$];
  logic [32:0]       fetch_q [$];
  logic [ADDR_W+8:0] acc_exp, acc_got;
  logic [32:0]       res_exp, res_got;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_en) begin
        n_checks++;
        acc_got = {mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00)};
        if (acc_q.size() == 0) begin
          $display("FAIL mem_access: got unexpected access %h, expected none", acc_got);
        end else begin
          acc_exp = acc_q.pop_front();
          if (acc_got !== acc_exp) $display("FAIL mem_access: got %h, expected %h", acc_got, acc_exp);
          else n_pass++;
        end
      end
      if (fetch_valid) begin
        n_checks++;
        res_got = {fetch_err, fetch_data};
        if (fetch_q.size() == 0) begin
          $display("FAIL fetch_result: got unexpected result %h, expected none", res_got);
        end else begin
          res_exp = fetch_q.pop_front();
          if (res_got !== res_exp) $display("FAIL fetch_result: got %h, expected %h", res_got, res_exp);
          else n_pass++;
        end
      end
    end
  end

  function automatic logic [55:0] all_outs();
    return {fetch_gnt, fetch_valid, fetch_data, fetch_err, load_gnt, mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  function automatic logic [31:0] exp_word(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] b;
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      b = a + ADDR_W'(k);
      w[8*k +: 8] = mem[b];
    end
    return w;
  endfunction

  // Drives one fetch, queues its expectations, returns grant seen, grant cycle and cycles until fetch_valid.
  task automatic run_fetch(input logic [31:0] a, input logic [31:0] d, input logic e, input int n_acc,
                           output logic g, output int gc, output int lat);
    logic [ADDR_W-1:0] ad;
    for (int k = 0; k < n_acc; k++) begin
      ad = a[ADDR_W-1:0] + ADDR_W'(k);
      acc_q.push_back({1'b0, ad, 8'h00});
    end
    fetch_q.push_back({e, d});
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = a;
    @(negedge clk);
    g = fetch_gnt; gc = cyc;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (fetch_valid) begin lat = c; break; end
    end
  endtask

  // Drives one load, queues its write, returns grant seen, grant cycle and the strobe seen in T1.
  task automatic run_load(input logic [ADDR_W-1:0] a, input logic [7:0] d,
                          output logic g, output int gc, output logic [ADDR_W+1:0] seen);
    acc_q.push_back({1'b1, a, d});
    @(posedge clk); #1;
    load_req = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    g = load_gnt; gc = cyc;
    @(posedge clk); #1;
    load_req = 1'b0;
    @(negedge clk);
    seen = {mem_en, mem_we, mem_addr};
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_req = 1'b0; load_req = 1'b0;
    fetch_addr = '0; load_addr = '0; load_data = '0;
    repeat (2) @(posedge clk);
    #1; fetch_req = 1'b1; load_req = 1'b1; fetch_addr = 32'd4; load_addr = 10'd8;
    @(negedge clk);
    n_checks++;
    if ({fetch_gnt, load_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b, expected 00", {fetch_gnt, load_gnt});
    else n_pass++;
    n_checks++;
    if (all_outs() !== 56'd0) $display("FAIL reset_outs: got %h, expected 0", all_outs());
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; fetch_req = 1'b0; load_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (all_outs() !== 56'd0) $display("FAIL post_reset_outs: got %h, expected 0", all_outs());
      else n_pass++;
    end
  endtask

  task automatic test_aligned();
    logic g; int gc, lat;
    mem[4] = 8'h33; mem[5] = 8'h81; mem[6] = 8'h20; mem[7] = 8'h00;
    run_fetch(32'd4, 32'h00208133, 1'b0, 4, g, gc, lat);
    n_checks++;
    if (g !== 1'b1) $display("FAIL aligned_gnt: got %b, expected 1", g); else n_pass++;
    n_checks++;
    if (lat != 6) $display("FAIL aligned_latency: got %0d, expected 6", lat); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({fetch_valid, mem_en} !== 2'b00) $display("FAIL aligned_idle: got %b, expected 00", {fetch_valid, mem_en});
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (fetch_data !== 32'h00208133) $display("FAIL data_hold: got %h, expected 00208133", fetch_data);
    else n_pass++;
  endtask

  task automatic test_load_fetch();
    logic g; int gc, lat; logic [ADDR_W+1:0] seen; logic [31:0] d;
    run_load(10'd8, 8'h13, g, gc, seen);
    n_checks++;
    if (g !== 1'b1) $display("FAIL load_gnt: got %b, expected 1", g); else n_pass++;
    n_checks++;
    if (seen !== {2'b11, 10'd8}) $display("FAIL load_strobe: got %h, expected %h", seen, {2'b11, 10'd8});
    else n_pass++;
    d = {mem[11], mem[10], mem[9], 8'h13};
    run_fetch(32'd8, d, 1'b0, 4, g, gc, lat);
    n_checks++;
    if (fetch_data[7:0] !== 8'h13) $display("FAIL load_readback: got %h, expected 13", fetch_data[7:0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic g1, g2; int gc1, gc2, lat; logic [ADDR_W+1:0] seen;
    run_fetch(32'h30, exp_word(10'h30), 1'b0, 4, g1, gc1, lat);
    run_fetch(32'h34, exp_word(10'h34), 1'b0, 4, g2, gc2, lat);
    n_checks++;
    if (!(g1 && g2) || (gc2 - gc1) != 7) $display("FAIL fetch_gap: got %0d, expected 7", gc2 - gc1);
    else n_pass++;
    run_load(10'h50, 8'hA1, g1, gc1, seen);
    run_load(10'h51, 8'hB2, g2, gc2, seen);
    n_checks++;
    if (!(g1 && g2) || (gc2 - gc1) != 2) $display("FAIL load_gap: got %0d, expected 2", gc2 - gc1);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic g; int gc, lat;
    mem[1020] = 8'h11; mem[1021] = 8'h22; mem[1022] = 8'h33; mem[1023] = 8'h44;
    mem[0] = 8'h55; mem[1] = 8'h66;
    run_fetch(32'd1020, 32'h44332211, 1'b0, 4, g, gc, lat);
    n_checks++;
    if (fetch_data !== 32'h44332211) $display("FAIL wrap_1020: got %h, expected 44332211", fetch_data);
    else n_pass++;
`ifdef IMEM_ALIGN_CHK_EN
    run_fetch(32'd1022, 32'h0, 1'b1, 0, g, gc, lat);
    n_checks++;
    if ({fetch_err, fetch_data} !== 33'h1_0000_0000) $display("FAIL wrap_1022: got %h, expected 100000000", {fetch_err, fetch_data});
    else n_pass++;
`else
    run_fetch(32'd1022, 32'h66554433, 1'b0, 4, g, gc, lat);
    n_checks++;
    if (fetch_data !== 32'h66554433) $display("FAIL wrap_1022: got %h, expected 66554433", fetch_data);
    else n_pass++;
`endif
  endtask

  task automatic test_misaligned();
    logic g; int gc, lat;
`ifdef IMEM_ALIGN_CHK_EN
    run_fetch(32'd6, 32'h0, 1'b1, 0, g, gc, lat);
    n_checks++;
    if (lat != 1) $display("FAIL misaligned_latency: got %0d, expected 1", lat); else n_pass++;
`else
    run_fetch(32'd6, exp_word(10'd6), 1'b0, 4, g, gc, lat);
    n_checks++;
    if (lat != 6) $display("FAIL misaligned_latency: got %0d, expected 6", lat); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    logic g; int gc, lat; logic seen_valid, seen_en; logic [ADDR_W-1:0] ad;
    for (int k = 0; k < 4; k++) begin
      ad = 10'h40 + ADDR_W'(k);
      acc_q.push_back({1'b0, ad, 8'h00});
    end
    @(posedge clk); #1; fetch_req = 1'b1; fetch_addr = 32'h40;
    @(negedge clk);
    n_checks++;
    if (fetch_gnt !== 1'b1) $display("FAIL midrst_gnt: got %b, expected 1", fetch_gnt); else n_pass++;
    @(posedge clk); #1; fetch_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (all_outs() !== 56'd0) $display("FAIL midrst_outs: got %h, expected 0", all_outs()); else n_pass++;
    seen_valid = 1'b0; seen_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fetch_valid) seen_valid = 1'b1;
      if (mem_en) seen_en = 1'b1;
    end
    n_checks++;
    if ({seen_valid, seen_en} !== 2'b00) $display("FAIL midrst_quiet: got %b, expected 00", {seen_valid, seen_en});
    else n_pass++;
    n_checks++;
    if (acc_q.size() != 2) $display("FAIL midrst_reads: got %0d pending, expected 2", acc_q.size()); else n_pass++;
    acc_q.delete();
    run_fetch(32'h40, exp_word(10'h40), 1'b0, 4, g, gc, lat);
    n_checks++;
    if (!g || lat != 6) $display("FAIL midrst_recover: got gnt=%b lat=%0d, expected gnt=1 lat=6", g, lat);
    else n_pass++;
  endtask

  task automatic test_contention();
    int gcyc[4]; logic kind[4]; int exp_cyc[4]; logic exp_kind[4];
    int ng; logic bad;
    exp_cyc[0] = 0; exp_cyc[1] = 7; exp_cyc[2] = 9; exp_cyc[3] = 16;
    exp_kind[0] = 1'b0; exp_kind[1] = 1'b1; exp_kind[2] = 1'b0; exp_kind[3] = 1'b1;
    mem[16] = 8'hDE; mem[17] = 8'hAD; mem[18] = 8'hBE; mem[19] = 8'hEF;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) acc_q.push_back({1'b0, 10'(16 + k), 8'h00});
      acc_q.push_back({1'b1, 10'h20, 8'hA5});
      fetch_q.push_back({1'b0, 32'hEFBEADDE});
    end
    @(posedge clk); #1;
    rst = 1'b1; fetch_req = 1'b1; load_req = 1'b1;
    fetch_addr = 32'h10; load_addr = 10'h20; load_data = 8'hA5;
    @(posedge clk); #1; rst = 1'b0;
    ng = 0; bad = 1'b0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(negedge clk);
      if ((fetch_valid && mem_en) || (fetch_gnt && load_gnt)) bad = 1'b1;
      if (fetch_gnt) begin gcyc[ng] = c; kind[ng] = 1'b0; ng++; end
      else if (load_gnt) begin gcyc[ng] = c; kind[ng] = 1'b1; ng++; end
    end
    @(posedge clk); #1; fetch_req = 1'b0; load_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fetch_valid && mem_en) bad = 1'b1;
    end
    n_checks++;
    if (ng != 4) $display("FAIL contention_count: got %0d grants, expected 4", ng); else n_pass++;
    for (int i = 0; i < ng; i++) begin
      n_checks++;
      if (kind[i] !== exp_kind[i] || gcyc[i] != exp_cyc[i])
        $display("FAIL contention_grant%0d: got load=%b cycle=%0d, expected load=%b cycle=%0d",
                 i, kind[i], gcyc[i], exp_kind[i], exp_cyc[i]);
      else n_pass++;
    end
    n_checks++;
    if (bad !== 1'b0) $display("FAIL contention_overlap: got 1, expected 0"); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i * 37 + 5);
    test_reset();
    test_aligned();
    test_load_fetch();
    test_back_to_back();
    test_wrap();
    test_misaligned();
    test_reset_mid();
    test_contention();
    repeat (3) @(negedge clk);
    n_checks++;
    if (acc_q.size() != 0 || fetch_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d accesses and %0d results pending, expected 0 and 0",
               acc_q.size(), fetch_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_port_arb.md
IMEM_PORT_ARB -- requirements
Module: imem_port_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning byte-address width of the instruction memory (1024 bytes).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch requester wants a 32-bit instruction.
- fetch_addr  in  32  byte address of the instruction; bits [ADDR_W-1:0] used.
- fetch_gnt  out  1  one-cycle pulse; fetch_addr latched.
- fetch_valid  out  1  one-cycle pulse; fetch_data valid.
- fetch_data  out  32  assembled instruction, little-endian.
- fetch_err  out  1  misaligned fetch; qualified by fetch_valid.
- load_req  in  1  loader wants to write one byte.
- load_addr  in  ADDR_W  loader byte address.
- load_data  in  8  loader byte.
- load_gnt  out  1  one-cycle pulse; load_addr/load_data latched.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte, valid the cycle after a read strobe.

Function
REQ-003 SHALL implement FSM states IDLE, RD, CAP, DONE, WR; memory accessed only from RD and WR.
REQ-004 In IDLE, with exactly one request high, SHALL grant it: pulse its gnt, latch its address/data, and move to RD (fetch) or WR (load).
REQ-005 In IDLE, with both requests high, SHALL grant the requester not granted most recently (round-robin); the grant history updates on every grant.
REQ-006 SHALL not grant in any state other than IDLE; a requester holds req, address and data stable until its gnt.
REQ-007 Fetch timing, grant cycle T0: RD drives mem_en=1, mem_we=0, mem_addr=latched addr+k for k=0..3 in T1..T4.
REQ-008 SHALL capture mem_rdata into byte k of fetch_data at the end of cycle T2+k; CAP is T5 (last capture).
REQ-009 SHALL be in DONE during T6, with fetch_valid=1, fetch_err=0 and fetch_data complete; SHALL return to IDLE in T7, so back-to-back fetch grants are 7 cycles apart.
REQ-010 Address arithmetic SHALL be modulo 2^ADDR_W: addr+k wraps from 1023 to 0.
REQ-011 fetch_data SHALL hold its value until the next fetch's first capture.
REQ-012 Load timing, grant cycle T0: WR in T1 drives mem_en=1, mem_we=1, latched address and data; SHALL return to IDLE in T2.
REQ-013 Outside RD and WR, mem_en and mem_we SHALL be 0.
REQ-014 A request arriving during a busy state SHALL wait and be arbitrated on the first IDLE cycle.

Reset
REQ-015 On rst high at a clock edge, SHALL go to IDLE and drive all outputs 0: fetch_gnt, fetch_valid, fetch_data, fetch_err, load_gnt, mem_en, mem_we, mem_addr, mem_wdata.
REQ-016 On that same reset, SHALL set the round-robin history so the first contended grant goes to fetch.
REQ-017 Reset mid-operation SHALL abandon the transaction with no fetch_valid and no further memory strobe.
REQ-018 Requests sampled during a reset cycle SHALL be ignored.

Configuration
REQ-019 Macro IMEM_ALIGN_CHK_EN, when defined: a fetch granted with fetch_addr[1:0]!=0 SHALL skip RD/CAP, issue no memory access, and go to DONE in T1 with fetch_valid=1, fetch_err=1, fetch_data=0.
REQ-020 When IMEM_ALIGN_CHK_EN is undefined: fetch_err SHALL be tied 0, and misaligned fetches SHALL read bytes addr..addr+3 per REQ-007 to REQ-010.

Verification
REQ-021 Aligned fetch:
- Stimulus: bytes 4..7 preloaded 33,81,20,00 (hex); fetch_req at addr 4.
- Response: fetch_gnt at T0; reads of 4,5,6,7 in T1..T4; fetch_valid in T6 with fetch_data=0x00208133, fetch_err=0.
REQ-022 Load then fetch:
- Stimulus: loader writes 0x13 to 8.
- Response: load_gnt at T0; mem_we=1 with addr 8 in T1.
- Stimulus: then fetch addr 8.
- Response: fetch_data[7:0]=0x13.
REQ-023 Contention, both requests held from reset release:
- Required grant order: fetch, load, fetch, load.
- No mem_en during a DONE cycle.
REQ-024 Wrap:
- Stimulus: fetch at addr 1020; ADDR_W=10 (default); IMEM_ALIGN_CHK_EN undefined.
- Response: reads 1020..1023; fetch_data is those 4 bytes.
- Stimulus: fetch at 1022.
- Response: reads 1022,1023,0,1.
REQ-025 Misaligned fetch at addr 6:
- With IMEM_ALIGN_CHK_EN defined: fetch_valid=1, fetch_err=1, data 0 at T1; mem_en never asserted.
- Without it: bytes 6..9 returned at T6.
REQ-026 Reset mid-fetch:
- Stimulus: rst high at T3 of a fetch.
- Response: all outputs 0 from T4; no fetch_valid; next request granted from IDLE normally.
